// File: rtl/reg_int_gen.sv
// reg_int_gen: CPU register interface for the 1GbE MAC.
//
// A bank of NUM_REGS configuration registers, each with its own reset value
// taken from REG_INIT. Registers flagged in PULSE_MASK are self-clearing: a
// written value lasts one cycle, then the register reloads its reset value.
// A write happens only on the rising edge of the write request, so a held
// access writes once. Three status words follow the bank. They drive a
// request/grant engine that copies one 32-bit RMON statistic into a snapshot
// register.
//
// Register map (word index = CA[ADDR_W-1:1]):
//   0..NUM_REGS-1  configuration registers
//   NUM_REGS       STAT_CTRL  write: statistic address, starts a read
//                             read : {overrun, timeout, done, busy}
//   NUM_REGS+1     STAT_LO    snapshot[DATA_W-1:0]
//   NUM_REGS+2     STAT_HI    snapshot[31:16] (reads 0 when DATA_W=32)
//   NUM_REGS+3     LOCK       only with REG_INT_WRITE_LOCK_EN, otherwise reads 0
//
// Optional feature macro: REG_INT_WRITE_LOCK_EN
//   When defined, the LOCK word resets to locked (reads 1). Writing 16'hA5C3
//   unlocks it; writing any other value locks it. While locked, writes to the
//   configuration registers are dropped.
//
// Ports:
//   Clk_reg       register clock
//   Reset_n       asynchronous active-low reset
//   CSB, WRB      chip select (active-low), 0=write / 1=read
//   CA, CD_in     byte address, write data
//   CD_out        registered read data (one cycle latency)
//   regs_out      flattened configuration registers, register i at [i*DATA_W +: DATA_W]
//   CPU_rd_addr   RMON statistic address
//   CPU_rd_apply  RMON read request
//   CPU_rd_grant  RMON grant; CPU_rd_dout is valid while high
//   CPU_rd_dout   RMON statistic data
//   stat_busy     statistic read in progress
module reg_int_gen #(
    parameter int unsigned                   NUM_REGS   = 35,
    parameter int unsigned                   DATA_W     = 16,
    parameter int unsigned                   ADDR_W     = 8,
    parameter logic [NUM_REGS*DATA_W-1:0]    REG_INIT   = '0,
    parameter logic [NUM_REGS-1:0]           PULSE_MASK = '0,
    parameter int unsigned                   STAT_AW    = 6,
    parameter int unsigned                   TIMEOUT    = 255
) (
    input  logic                       Clk_reg,
    input  logic                       Reset_n,
    input  logic                       CSB,
    input  logic                       WRB,
    input  logic [ADDR_W-1:0]          CA,
    input  logic [DATA_W-1:0]          CD_in,
    output logic [DATA_W-1:0]          CD_out,
    output logic [NUM_REGS*DATA_W-1:0] regs_out,
    output logic [STAT_AW-1:0]         CPU_rd_addr,
    output logic                       CPU_rd_apply,
    input  logic                       CPU_rd_grant,
    input  logic [31:0]                CPU_rd_dout,
    output logic                       stat_busy
);

    localparam int unsigned IDX_CTRL = NUM_REGS;
    localparam int unsigned IDX_LO   = NUM_REGS + 1;
    localparam int unsigned IDX_HI   = NUM_REGS + 2;
    localparam int unsigned IDX_LOCK = NUM_REGS + 3;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StReq, StRel} stat_state_e;

    // Address decode and access strobes
    logic [ADDR_W-2:0] idx;
    int unsigned       idx_u;
    logic              unused_ca0;
    logic              wr_req, rd_req, wr_req_q, wr_pulse, cfg_wr_en;

    assign idx        = CA[ADDR_W-1:1];
    assign idx_u      = 32'(idx);
    assign unused_ca0 = CA[0];
    assign wr_req     = !CSB && !WRB;
    assign rd_req     = !CSB && WRB;
    assign wr_pulse   = wr_req && !wr_req_q;

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) wr_req_q <= 1'b0;
        else          wr_req_q <= wr_req;
    end

`ifdef REG_INT_WRITE_LOCK_EN
    logic lock_q, lock_d;

    always_comb begin
        lock_d = lock_q;
        if (wr_pulse && idx_u == IDX_LOCK) lock_d = (CD_in[15:0] != 16'hA5C3);
    end

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) lock_q <= 1'b1;
        else          lock_q <= lock_d;
    end

    assign cfg_wr_en = wr_pulse && !lock_q;
`else
    assign cfg_wr_en = wr_pulse;
`endif

    // Configuration bank
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            // Self-clearing registers fall back to their reset value unless rewritten
            if (PULSE_MASK[i])                regs_d[i] = REG_INIT[i*DATA_W +: DATA_W];
            if (cfg_wr_en && idx_u == i)      regs_d[i] = CD_in;
        end
    end

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_INIT[i*DATA_W +: DATA_W];
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_out[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // Statistic read engine
    stat_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [STAT_AW-1:0] addr_q, addr_d;
    logic [31:0]        snap_q, snap_d;
    logic               done_q, done_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               ctrl_wr;

    assign ctrl_wr = wr_pulse && idx_u == IDX_CTRL;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        snap_d    = snap_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_wr) begin
                    addr_d    = CD_in[STAT_AW-1:0];
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    overrun_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Grant is checked first so it wins over a coincident timeout
                if (CPU_rd_grant) begin
                    snap_d  = CPU_rd_dout;
                    done_d  = 1'b1;
                    state_d = StRel;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = StRel;
                end
                if (ctrl_wr) overrun_d = 1'b1;
            end
            StRel: begin
                if (ctrl_wr) overrun_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            addr_q    <= '0;
            snap_q    <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            snap_q    <= snap_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    // Decoded from state so the request drops as soon as reset asserts
    assign CPU_rd_apply = (state_q == StReq);
    assign stat_busy    = (state_q != StIdle);
    assign CPU_rd_addr  = addr_q;

    // Read path
    logic [DATA_W-1:0] stat_hi;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] cd_out_q, cd_out_d;

    if (DATA_W == 32) begin : g_hi32
        assign stat_hi = '0;
    end else begin : g_hi16
        assign stat_hi = snap_q[31:16];
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (idx_u == i) rd_data = regs_q[i];
        end
        if (idx_u == IDX_CTRL) rd_data = DATA_W'({overrun_q, timeout_q, done_q, stat_busy});
        if (idx_u == IDX_LO)   rd_data = snap_q[DATA_W-1:0];
        if (idx_u == IDX_HI)   rd_data = stat_hi;
`ifdef REG_INT_WRITE_LOCK_EN
        if (idx_u == IDX_LOCK) rd_data = DATA_W'(lock_q);
`endif
    end

    always_comb begin
        cd_out_d = cd_out_q;
        if (rd_req) cd_out_d = rd_data;
    end

    always_ff @(posedge Clk_reg or negedge Reset_n) begin
        if (!Reset_n) cd_out_q <= '0;
        else          cd_out_q <= cd_out_d;
    end

    assign CD_out = cd_out_q;

endmodule

// File: tb/tb_reg_int_gen.sv
// Directed bench for reg_int_gen: 35 x 16-bit bank, reg0=001e, reg26=2710,
// reg10 self-clearing, statistic timeout of 8 cycles.
module tb_reg_int_gen;

    localparam int NR = 35;
    localparam int DW = 16;
    localparam logic [NR*DW-1:0] INIT = ((NR*DW)'(16'h2710) << (26*DW)) | (NR*DW)'(16'h001e);
    localparam logic [NR-1:0] PMASK = NR'(1) << 10;
    localparam int CTRL = NR;
    localparam int LO   = NR + 1;
    localparam int HI   = NR + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              csb = 1'b1;
    logic              wrb = 1'b1;
    logic [7:0]        ca = '0;
    logic [DW-1:0]     cd_in = '0;
    logic [DW-1:0]     cd_out;
    logic [NR*DW-1:0]  regs_out;
    logic [5:0]        rd_addr;
    logic              rd_apply;
    logic              rd_grant = 1'b0;
    logic [31:0]       rd_dout = '0;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    int strobe_cnt = 0;

    always #5 clk = ~clk;

    reg_int_gen #(
        .NUM_REGS  (NR),
        .DATA_W    (DW),
        .ADDR_W    (8),
        .REG_INIT  (INIT),
        .PULSE_MASK(PMASK),
        .STAT_AW   (6),
        .TIMEOUT   (8)
    ) dut (
        .Clk_reg     (clk),
        .Reset_n     (rst_n),
        .CSB         (csb),
        .WRB         (wrb),
        .CA          (ca),
        .CD_in       (cd_in),
        .CD_out      (cd_out),
        .regs_out    (regs_out),
        .CPU_rd_addr (rd_addr),
        .CPU_rd_apply(rd_apply),
        .CPU_rd_grant(rd_grant),
        .CPU_rd_dout (rd_dout),
        .stat_busy   (busy)
    );

    always @(posedge clk) if (dut.wr_pulse) strobe_cnt <= strobe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the negedge after the committing edge
    task automatic wr(input int idx, input logic [15:0] d);
        @(negedge clk);
        csb = 1'b0; wrb = 1'b0; ca = 8'(idx * 2); cd_in = d;
        @(negedge clk);
        csb = 1'b1; wrb = 1'b1;
    endtask

    task automatic rd(input int idx, output logic [15:0] d);
        @(negedge clk);
        csb = 1'b0; wrb = 1'b1; ca = 8'(idx * 2);
        @(negedge clk);
        d = cd_out;
        csb = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("idle_bound", 32'(busy), 32'd0);
    endtask

    logic [15:0] v;
    int          n;
    int          c0;

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_reg0", 32'(regs_out[0*DW +: DW]), 32'h001e);
        check("rst_reg26", 32'(regs_out[26*DW +: DW]), 32'h2710);
        check("rst_reg3", 32'(regs_out[3*DW +: DW]), 32'h0000);
        check("rst_cdout", 32'(cd_out), 32'h0);
        check("rst_apply", 32'(rd_apply), 32'h0);
        check("rst_addr", 32'(rd_addr), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Read CA=52 with one-cycle latency
        @(negedge clk);
        csb = 1'b0; wrb = 1'b1; ca = 8'd52;
        #1 check("rd_latency_old", 32'(cd_out), 32'h0);
        @(negedge clk);
        check("rd_reg26", 32'(cd_out), 32'h2710);
        csb = 1'b1;

`ifdef REG_INT_WRITE_LOCK_EN
        rd(NR + 3, v); check("lock_rst", 32'(v), 32'h1);
        wr(0, 16'h0007);
        rd(0, v); check("lock_blocked", 32'(v), 32'h001e);
        wr(NR + 3, 16'hA5C3);
        rd(NR + 3, v); check("lock_open", 32'(v), 32'h0);
        wr(0, 16'h0007);
        rd(0, v); check("lock_wr_ok", 32'(v), 32'h0007);
`else
        rd(NR + 3, v); check("lock_absent", 32'(v), 32'h0);
        wr(0, 16'h0007);
        rd(0, v); check("wr_reg0", 32'(v), 32'h0007);
`endif

        // Plain write/read-back, unmapped read, CD_out hold
        wr(5, 16'hA5A5);
        check("wr5_regs_out", 32'(regs_out[5*DW +: DW]), 32'hA5A5);
        rd(40, v); check("rd_unmapped", 32'(v), 32'h0);
        rd(5, v); check("rd_reg5", 32'(v), 32'hA5A5);
        repeat (3) @(negedge clk);
        check("cdout_hold", 32'(cd_out), 32'hA5A5);
        check("reg5_hold", 32'(regs_out[5*DW +: DW]), 32'hA5A5);

        // Held write fires once; changing data mid-hold must not land
        c0 = strobe_cnt;
        @(negedge clk);
        csb = 1'b0; wrb = 1'b0; ca = 8'd6; cd_in = 16'h1234;
        @(negedge clk);
        check("held_first", 32'(regs_out[3*DW +: DW]), 32'h1234);
        cd_in = 16'h5678;
        repeat (4) @(negedge clk);
        csb = 1'b1; wrb = 1'b1;
        check("held_value", 32'(regs_out[3*DW +: DW]), 32'h1234);
        check("held_strobes", 32'(strobe_cnt - c0), 32'd1);

        // Self-clearing register
        wr(10, 16'h0001);
        check("pulse_hi", 32'(regs_out[10*DW +: DW]), 32'h0001);
        @(negedge clk);
        check("pulse_lo", 32'(regs_out[10*DW +: DW]), 32'h0000);

        // Statistic read, grant after three request cycles
        wr(CTRL, 16'd5);
        check("st_apply1", 32'(rd_apply), 32'h1);
        check("st_addr", 32'(rd_addr), 32'd5);
        check("st_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("st_apply2", 32'(rd_apply), 32'h1);
        @(negedge clk);
        check("st_apply3", 32'(rd_apply), 32'h1);
        rd_grant = 1'b1; rd_dout = 32'hDEADBEEF;
        @(negedge clk);
        rd_grant = 1'b0; rd_dout = '0;
        check("st_rel_apply", 32'(rd_apply), 32'h0);
        check("st_rel_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("st_idle", 32'(busy), 32'h0);
        rd(CTRL, v); check("st_status", 32'(v), 32'h2);
        rd(LO, v); check("st_lo", 32'(v), 32'hBEEF);
        rd(HI, v); check("st_hi", 32'(v), 32'hDEAD);

        // Timeout: apply high for exactly TIMEOUT cycles
        wr(CTRL, 16'd9);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (rd_apply) n++;
            @(negedge clk);
        end
        check("to_cycles", 32'(n), 32'd8);
        rd(CTRL, v); check("to_status", 32'(v), 32'h4);
        check("to_addr", 32'(rd_addr), 32'd9);
        rd(LO, v); check("to_lo_kept", 32'(v), 32'hBEEF);
        rd(HI, v); check("to_hi_kept", 32'(v), 32'hDEAD);

        // Overrun: second STAT_CTRL write during REQ
        wr(CTRL, 16'd7);
        rd(CTRL, v); check("ov_busy_rd", 32'(v), 32'h1);
        wr(CTRL, 16'd12);
        check("ov_addr_kept", 32'(rd_addr), 32'd7);
        wait_idle();
        rd(CTRL, v); check("ov_status", 32'(v), 32'hC);

        // Grant on the final count: grant wins
        wr(CTRL, 16'd3);
        repeat (7) @(negedge clk);
        check("gt_apply8", 32'(rd_apply), 32'h1);
        rd_grant = 1'b1; rd_dout = 32'hCAFEF00D;
        @(negedge clk);
        rd_grant = 1'b0; rd_dout = '0;
        wait_idle();
        rd(CTRL, v); check("gt_status", 32'(v), 32'h2);
        rd(LO, v); check("gt_lo", 32'(v), 32'hF00D);

        // Reset mid-transaction
        wr(CTRL, 16'd1);
        check("mr_apply_pre", 32'(rd_apply), 32'h1);
        #2 rst_n = 1'b0;
        #1 check("mr_apply_async", 32'(rd_apply), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(LO, v); check("mr_snap_lo", 32'(v), 32'h0);
        rd(HI, v); check("mr_snap_hi", 32'(v), 32'h0);
        check("mr_reg0", 32'(regs_out[0*DW +: DW]), 32'h001e);
        check("mr_reg5", 32'(regs_out[5*DW +: DW]), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
